// File: rtl/frame2dcache_packer.sv
// frame2dcache_packer
//
// Packs a byte stream from the frame side into 16-bit little-endian words for
// the dcache side. Odd-length frames finish with a half word whose high byte is
// PAD_BYTE and whose keep is 2'b01. Words wait in a small FIFO of
// 2^DEPTH_WIDTH entries.
//
// Ports
//   clk, rst_n            : single rising-edge clock, async active-low reset
//   in_vld/in_rdy         : byte handshake (in_data, in_last)
//   out_vld/out_rdy       : word handshake (out_data, out_keep, out_last)
//   level                 : number of buffered words
//   frame_cnt             : number of completed frames pushed (optional)
//   o_dbg_state           : packer FSM state (0 = EMPTY, 1 = HALF)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A valid source keeps its payload stable until that
// edge. in_rdy and out_vld depend only on registered state, never on the other
// side's valid/ready in the same cycle.
//
// Optional feature: define FRAME2DCACHE_FRAME_CNT_EN to build the frame counter.
// Without it, frame_cnt is tied to zero.
`timescale 1ns/1ps
module frame2dcache_packer #(
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [15:0]          out_data,
  output logic [1:0]           out_keep,
  output logic                 out_last,
  output logic [DEPTH_WIDTH:0] level,
  output logic [15:0]          frame_cnt,
  output logic                 o_dbg_state
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = (DEPTH_WIDTH)'(1);

  typedef enum logic {S_EMPTY = 1'b0, S_HALF = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_held;
  logic                   r_alive;
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [DEPTH_WIDTH:0]   r_level;
  // FIFO entry layout: {last, keep[1:0], data[15:0]}
  logic [18:0]            r_mem [DEPTH];

  logic                   w_in_fire;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_hold;
  logic [18:0]            w_push_word;
  logic [18:0]            w_head;

  // r_alive keeps in_rdy low until the first edge after reset is released.
  assign in_rdy    = r_alive && (r_level < LVL_FULL);
  assign w_in_fire = in_vld && in_rdy;
  assign out_vld   = (r_level != '0);
  assign w_pop     = out_vld && out_rdy;
  assign level     = r_level;
  assign o_dbg_state = r_state;

  // The memory has no reset, so the head word is gated to zero when the FIFO is empty.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = out_vld ? w_head[15:0]  : 16'h0000;
  assign out_keep  = out_vld ? w_head[17:16] : 2'b00;
  assign out_last  = out_vld ? w_head[18]    : 1'b0;

  // Packer FSM: next state and push decision
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_hold      = 1'b0;
    w_push_word = '0;
    if (w_in_fire) begin
      case (r_state)
        S_EMPTY: begin
          if (in_last) begin
            w_push      = 1'b1;
            w_push_word = {1'b1, 2'b01, PAD_BYTE, in_data};
          end else begin
            w_hold      = 1'b1;
            w_state_nxt = S_HALF;
          end
        end
        S_HALF: begin
          w_push      = 1'b1;
          w_push_word = {in_last, 2'b11, in_data, r_held};
          w_state_nxt = S_EMPTY;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_held   <= 8'h00;
      r_alive  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      if (w_hold) r_held <= in_data;
      // The pointers wrap naturally because the FIFO depth is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // A push can only happen when in_rdy=1, so the level never passes full.
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

`ifdef FRAME2DCACHE_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_frame_cnt <= 16'h0000;
    else if (w_push && w_push_word[18])  r_frame_cnt <= r_frame_cnt + 16'h0001;
  end
  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_frame2dcache_packer.sv
`timescale 1ns/1ps
module tb_frame2dcache_packer;

  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam logic [7:0] PAD = 8'h00;
`ifdef FRAME2DCACHE_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_last;
  logic [DW:0] level;
  logic [15:0] frame_cnt;
  logic        dbg_state;

  always #5 clk = ~clk;

  frame2dcache_packer #(.DEPTH_WIDTH(DW), .PAD_BYTE(PAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .level(level), .frame_cnt(frame_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];    // {last, keep, data} of words the DUT must hold, in order
  logic [18:0] out_log[$];  // words actually consumed on the output side
  logic [7:0]  m_bytes[$];  // bytes of the word being assembled
  int          m_frames = 0;
  bit          m_alive = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect bytes, emit a word once two bytes or the frame end arrive.
  task automatic model_accept(input logic [7:0] b, input logic last);
    m_bytes.push_back(b);
    if (m_bytes.size() == 2) begin
      exp_q.push_back({last, 2'b11, m_bytes[1], m_bytes[0]});
      m_bytes.delete();
      if (last) m_frames++;
    end else if (last) begin
      exp_q.push_back({1'b1, 2'b01, PAD, m_bytes[0]});
      m_bytes.delete();
      m_frames++;
    end
  endtask

  // Compare process: outputs are sampled on the falling edge, then the model
  // absorbs the handshakes that the next rising edge will commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_vld",   32'(out_vld),   32'd0);
      check("rst_level",     32'(level),     32'd0);
      check("rst_in_rdy",    32'(in_rdy),    32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_keep",  32'(out_keep),  32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_q.delete();
      m_bytes.delete();
      m_frames = 0;
      m_alive  = 1'b0;
    end else begin
      check("out_vld",   32'(out_vld), 32'(exp_q.size() != 0));
      check("level",     32'(level),   32'(exp_q.size()));
      check("in_rdy",    32'(in_rdy),  32'(m_alive && (exp_q.size() < DEPTH)));
      check("frame_cnt", 32'(frame_cnt), FC_EN ? 32'(m_frames[15:0]) : 32'd0);
      if (out_vld && exp_q.size() != 0) begin
        check("out_word", 32'({out_last, out_keep, out_data}), 32'(exp_q[0]));
        if (out_rdy) begin
          out_log.push_back({out_last, out_keep, out_data});
          void'(exp_q.pop_front());
        end
      end
      if (in_vld && in_rdy) model_accept(in_data, in_last);
      m_alive = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit done = 1'b0;
    in_vld  = 1'b1;
    in_data = b;
    in_last = last;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && level != 0; i++) idle(1);
    check("drain_level", 32'(level), 32'd0);
    idle(1);
  endtask

  task automatic check_word(input string name, input int idx, input logic [18:0] exp);
    logic [18:0] act;
    act = '1;
    if (idx < out_log.size()) act = out_log[idx];
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    idle(3);
    rst_n = 1'b1;
    check("in_rdy_low_before_edge", 32'(in_rdy), 32'd0);
    idle(1);
    check("in_rdy_after_reset", 32'(in_rdy), 32'd1);

    // Even frame, consumer always ready
    out_rdy = 1'b1;
    out_log.delete();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    drain();
    check("even_count", 32'(out_log.size()), 32'd2);
    check_word("even_w0", 0, {1'b0, 2'b11, 16'h2211});
    check_word("even_w1", 1, {1'b1, 2'b11, 16'h4433});
    check("even_frame_cnt", 32'(frame_cnt), FC_EN ? 32'd1 : 32'd0);

    // Odd frame ends with a padded half word
    out_log.delete();
    send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hC3, 1'b1);
    drain();
    check("odd_count", 32'(out_log.size()), 32'd2);
    check_word("odd_w0", 0, {1'b0, 2'b11, 16'hB2A1});
    check_word("odd_w1", 1, {1'b1, 2'b01, 16'h00C3});

    // Back-pressure: 10 bytes with consumer stalled
    out_rdy = 1'b0;
    out_log.delete();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("bp_level_full", 32'(level), 32'd4);
    check("bp_in_rdy_low", 32'(in_rdy), 32'd0);
    fork
      begin
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b1);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_head_stable", 32'(out_data), 32'h0201);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(out_log.size()), 32'd5);
    check_word("bp_w0", 0, {1'b0, 2'b11, 16'h0201});
    check_word("bp_w1", 1, {1'b0, 2'b11, 16'h0403});
    check_word("bp_w2", 2, {1'b0, 2'b11, 16'h0605});
    check_word("bp_w3", 3, {1'b0, 2'b11, 16'h0807});
    check_word("bp_w4", 4, {1'b1, 2'b11, 16'h0A09});

    // Full buffer with pop and offered byte in the same cycle
    out_rdy = 1'b0;
    out_log.delete();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    in_vld  = 1'b1;
    in_data = 8'h18;
    in_last = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("full_in_rdy_low", 32'(in_rdy), 32'd0);
    check("full_level", 32'(level), 32'd4);
    @(posedge clk);
    #1;
    check("full_pop_level", 32'(level), 32'd3);
    check("full_in_rdy_back", 32'(in_rdy), 32'd1);
    send_byte(8'h18, 1'b0);
    send_byte(8'h19, 1'b1);
    drain();
    check("full_count", 32'(out_log.size()), 32'd5);
    check_word("full_w0", 0, {1'b0, 2'b11, 16'h1110});
    check_word("full_w4", 4, {1'b1, 2'b11, 16'h1918});

    // Reset mid-frame with a held byte and two buffered words
    out_rdy = 1'b0;
    send_byte(8'h21, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0); send_byte(8'h24, 1'b0);
    send_byte(8'h25, 1'b0);
    check("mid_level", 32'(level), 32'd2);
    check("mid_state_half", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    out_rdy = 1'b1;
    out_log.delete();
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b1);
    drain();
    check("post_rst_count", 32'(out_log.size()), 32'd1);
    check_word("post_rst_w0", 0, {1'b1, 2'b11, 16'h6655});

    // Three single-byte frames back to back
    reset_pulse();
    out_rdy = 1'b1;
    out_log.delete();
    for (int i = 0; i < 3; i++) send_byte(8'h7E, 1'b1);
    drain();
    check("single_count", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_word("single_w", i, {1'b1, 2'b01, 16'h007E});
    check("single_frame_cnt", 32'(frame_cnt), FC_EN ? 32'd3 : 32'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame2dcache_packer.md
FRAME2DCACHE_PACKER -- requirements
Module: frame2dcache_packer

Interface
REQ-001 SHALL have parameter DEPTH_WIDTH, default 2, meaning the internal word buffer holds 2^DEPTH_WIDTH entries (legal 1..4).
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00, meaning the fill value for the unused high byte of an odd-length frame's last word.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_vld  input  1  byte valid from the frame side.
REQ-006 SHALL have port in_rdy  output  1  byte accepted when in_vld&&in_rdy.
REQ-007 SHALL have port in_data  input  8  frame byte.
REQ-008 SHALL have port in_last  input  1  marks the final byte of a frame.
REQ-009 SHALL have port out_vld  output  1  word valid toward the dcache side.
REQ-010 SHALL have port out_rdy  input  1  word consumed when out_vld&&out_rdy.
REQ-011 SHALL have port out_data  output  16  packed word.
REQ-012 SHALL have port out_keep  output  2  byte enables; 2'b11 both bytes valid, 2'b01 low byte only.
REQ-013 SHALL have port out_last  output  1  word carries the frame's final byte.
REQ-014 SHALL have port level  output  DEPTH_WIDTH+1  number of words buffered.
REQ-015 SHALL have port frame_cnt  output  16  count of completed frames pushed.

Function
REQ-016 SHALL pack bytes little-endian: first accepted byte of a pair into out_data[7:0], second into out_data[15:8].
REQ-017 SHALL run a two-state packer FSM: EMPTY (no byte held), HALF (low byte held in register).
REQ-018 SHALL, in EMPTY on accepted byte with in_last=0, store the byte and go to HALF with no push.
REQ-019 SHALL, in EMPTY on accepted byte with in_last=1, push {PAD_BYTE,byte}, keep=2'b01, last=1, and stay EMPTY.
REQ-020 SHALL, in HALF on accepted byte, push {byte,held}, keep=2'b11, last=in_last, and go to EMPTY.
REQ-021 SHALL drive in_rdy = (level < 2^DEPTH_WIDTH), derived from registered state only; a same-cycle pop SHALL NOT raise in_rdy.
REQ-022 SHALL present a pushed word on out_vld/out_data/out_keep/out_last in the cycle after the pushing byte is accepted (1-cycle latency when buffer empty).
REQ-023 SHALL hold out_data/out_keep/out_last stable while out_vld=1 and out_rdy=0.
REQ-024 SHALL, on simultaneous push and pop, leave level unchanged and preserve word order.
REQ-025 SHALL wrap read/write pointers modulo 2^DEPTH_WIDTH; level SHALL never exceed 2^DEPTH_WIDTH nor underflow.
REQ-026 SHALL ignore out_rdy when out_vld=0 and ignore in_data when in_vld=0.

Reset
REQ-027 SHALL, while rst_n=0, force FSM EMPTY, pointers 0, level 0, in_rdy 0, out_vld 0, out_data 16'h0000, out_keep 2'b00, out_last 0, frame_cnt 0.
REQ-028 SHALL raise in_rdy the first clk edge after rst_n deasserts.
REQ-029 SHALL discard any held half-word and buffered words on reset assertion mid-frame; no partial word emitted afterwards.

Configuration
REQ-030 SHALL compile the frame counter only when macro FRAME2DCACHE_FRAME_CNT_EN is defined: frame_cnt increments by 1 (wrapping 16'hFFFF->0) on every push with last=1.
REQ-031 SHALL, without FRAME2DCACHE_FRAME_CNT_EN, tie frame_cnt to 16'h0000 with no counter register.

Verification
REQ-032 SHALL cover: bytes 8'h11,8'h22,8'h33,8'h44(last) with out_rdy=1 -> words 16'h2211 keep 11 last 0, then 16'h4433 keep 11 last 1; frame_cnt=1.
REQ-033 SHALL cover: odd frame 8'hA1,8'hB2,8'hC3(last) -> 16'hB2A1 keep 11, then 16'h00C3 keep 01 last 1.
REQ-034 SHALL cover: out_rdy=0, DEPTH_WIDTH=2, stream 10 bytes -> level reaches 4, in_rdy=0 after 8th byte, out_data stable; release out_rdy -> 5 words in order, no loss.
REQ-035 SHALL cover: full buffer with out_rdy=1 and in_vld=1 same cycle -> one pop, no push that cycle, in_rdy=1 next cycle.
REQ-036 SHALL cover: rst_n pulsed low while in HALF with 2 words buffered -> out_vld=0, level=0 immediately; next frame 8'h55,8'h66(last) -> 16'h6655 only.
REQ-037 SHALL cover: single-byte frame 8'h7E(last) repeated 3 times back-to-back -> three words 16'h007E keep 01 last 1; frame_cnt=3 with macro, 0 without.
